ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Parameters
REQ-001 The block SHALL take parameter ADDR_W, default 64, meaning the address width of the ports and the RAM.
REQ-002 The block SHALL take parameter DATA_W, default 64, meaning the data width of the ports and the RAM.
REQ-003 The block SHALL take parameter WAIT_CYCLES, default 1, meaning the number of ACCESS cycles per transaction; legal range is 1..15.

Interface
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  in  1  reset, asynchronous and active-low.
REQ-006 test_en  in  1  loader mode; when high, the loader port has absolute priority.
REQ-007 cpu_req / cpu_we  in  1 / 1  CPU request and write-not-read.
REQ-008 cpu_addr / cpu_wdata  in  ADDR_W / DATA_W  CPU address and write data.
REQ-009 cpu_ack / cpu_rdata  out  1 / DATA_W  CPU completion pulse and read data.
REQ-010 ld_req, ld_we, ld_addr, ld_wdata, ld_ack, ld_rdata  same directions and widths as the cpu_* set  loader port.
REQ-011 ram_cs / ram_we / ram_oe  out  1 / 1 / 1  RAM strobes.
REQ-012 ram_addr / ram_wdata  out  ADDR_W / DATA_W  RAM address and write data.
REQ-013 ram_wdata_en  out  1  tristate enable for the parent's bidirectional data bus.
REQ-014 ram_rdata  in  DATA_W  RAM read data.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have four states: IDLE, SETUP, ACCESS and DONE.
REQ-017 In IDLE, the block SHALL sample the requests at each edge and, if any is high, latch the winner's we, addr and wdata, record the granted port, and move to SETUP.
REQ-018 Arbitration: when test_en is 1, ld_req SHALL win and cpu_req SHALL never be granted; when test_en is 0, both ports SHALL be eligible and round-robin SHALL apply.
REQ-019 Round-robin rule: on a simultaneous request, the port not granted last SHALL win; last_grant SHALL reset to loader, so the CPU wins the first tie.
REQ-020 SETUP SHALL last 1 cycle with ram_cs=1, ram_addr valid, ram_we=0 and ram_oe=0.
REQ-021 ACCESS SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit counter, with ram_cs=1.
REQ-022 In ACCESS, a write SHALL drive ram_we=1 and ram_wdata_en=1; a read SHALL drive ram_oe=1.
REQ-023 On a read, the block SHALL capture ram_rdata into the granted port's rdata register at the final ACCESS edge.
REQ-024 DONE SHALL last 1 cycle with all RAM strobes 0 and the granted port's ack=1; the next state SHALL be IDLE unconditionally.
REQ-025 Latency: with the request sampled at edge k, ack SHALL be high in the cycle after edge k+1+WAIT_CYCLES; the minimum period between grants is WAIT_CYCLES+3 cycles.
REQ-026 rdata SHALL hold its value until the next read on that port; a write SHALL not alter rdata.
REQ-027 ram_addr and ram_wdata SHALL come from latched copies and SHALL be stable from SETUP through ACCESS, regardless of port input changes.
REQ-028 If the granted requester drops req mid-transaction, the transaction SHALL still complete and ack SHALL still pulse.
REQ-029 A change of test_en mid-transaction SHALL not abort the transaction; it SHALL affect the next IDLE arbitration only.
REQ-030 The ack of the non-granted port SHALL be 0 at all times.
REQ-031 A requester holding req high through ack SHALL be treated as a new request at the next IDLE sample.

Reset
REQ-032 While reset_n=0, the block SHALL be in IDLE and all outputs (acks, strobes, ram_wdata_en, busy, ram_addr, ram_wdata, both rdata) SHALL be 0, with last_grant=loader and the wait counter at 0.
REQ-033 Reset assertion mid-transaction SHALL drop all strobes immediately, without waiting for a clock edge, and SHALL produce no ack.
REQ-034 After reset_n rises, the first arbitration SHALL occur at the first rising edge of clk.

Verification
REQ-035 CPU read, test_en=0, WAIT_CYCLES=1, cpu_addr=0x10, RAM returns 0xDEAD_BEEF -> ram_cs high for 2 cycles, ram_oe high for 1, cpu_ack high 3 cycles after the request is sampled, cpu_rdata=0xDEAD_BEEF.
REQ-036 Loader write, test_en=1, ld_addr=0x20, ld_wdata=0x1234 -> ram_we=1 and ram_wdata_en=1 for 1 ACCESS cycle with ram_addr=0x20 and ram_wdata=0x1234, then ld_ack pulses for 1 cycle.
REQ-037 Both ports requesting continuously with test_en=0 -> grants alternate CPU, LD, CPU, LD, with acks 4 cycles apart.
REQ-038 Both ports requesting with test_en=1 -> only ld_ack pulses, and cpu_ack stays 0 across 10 transactions.
REQ-039 Assert reset_n=0 during ACCESS of a write -> ram_we and ram_cs go to 0 before the next edge, and no ack follows after release.
REQ-040 WAIT_CYCLES=3, cpu_req dropped in SETUP -> ACCESS lasts 3 cycles and cpu_ack still pulses once.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-port RAM arbiter: a CPU port and a loader (test) port share a single RAM.
// Each transaction is a SETUP cycle, WAIT_CYCLES ACCESS cycles and a DONE cycle
// in which the granted port sees a one-cycle ack.
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   test_en              loader mode: loader has absolute priority, CPU is locked out
//   cpu_* / ld_*         requester ports (req, we, addr, wdata in; ack, rdata out)
//   ram_cs/we/oe         RAM strobes
//   ram_addr/ram_wdata   latched transaction address and write data
//   ram_wdata_en         tristate enable for the parent's bidirectional data bus
//   ram_rdata            RAM read data
//   busy                 high whenever a transaction is in flight
module ram_arbiter #(
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              test_en,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ram_cs,
    output logic              ram_we,
    output logic              ram_oe,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wdata_en,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam int unsigned          CNT_W    = 4;
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic                 PORT_CPU = 1'b0;
    localparam logic                 PORT_LD  = 1'b1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               grant_q, grant_d;
    logic               last_q, last_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [DATA_W-1:0]  wdata_d;
    logic               cs_d, ram_we_d, oe_d, cpu_ack_d, ld_ack_d, busy_d;
    logic               cpu_cap, ld_cap;
    logic               cpu_elig, ld_win, cpu_win;

    // Arbitration, next state and next-cycle output values.
    always_comb begin
        cpu_elig = cpu_req & ~test_en;
        // On a tie the port not granted last wins.
        ld_win   = ld_req & (~cpu_elig | (last_q == PORT_CPU));
        cpu_win  = cpu_elig & ~ld_win;

        state_d  = state_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = ram_addr;
        wdata_d  = ram_wdata;
        cpu_cap  = 1'b0;
        ld_cap   = 1'b0;

        case (state_q)
            IDLE: begin
                if (ld_win | cpu_win) begin
                    state_d = SETUP;
                    grant_d = ld_win ? PORT_LD : PORT_CPU;
                    last_d  = ld_win ? PORT_LD : PORT_CPU;
                    we_d    = ld_win ? ld_we    : cpu_we;
                    addr_d  = ld_win ? ld_addr  : cpu_addr;
                    wdata_d = ld_win ? ld_wdata : cpu_wdata;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = '0;
            end
            ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    cpu_cap = ~we_q & (grant_q == PORT_CPU);
                    ld_cap  = ~we_q & (grant_q == PORT_LD);
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        cs_d      = (state_d == SETUP) | (state_d == ACCESS);
        ram_we_d  = (state_d == ACCESS) & we_d;
        oe_d      = (state_d == ACCESS) & ~we_d;
        cpu_ack_d = (state_d == DONE) & (grant_d == PORT_CPU);
        ld_ack_d  = (state_d == DONE) & (grant_d == PORT_LD);
        busy_d    = (state_d != IDLE);
    end

    // State and output registers; reset clears strobes without waiting for clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            grant_q      <= PORT_CPU;
            last_q       <= PORT_LD;
            we_q         <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            ram_cs       <= 1'b0;
            ram_we       <= 1'b0;
            ram_oe       <= 1'b0;
            ram_wdata_en <= 1'b0;
            cpu_ack      <= 1'b0;
            ld_ack       <= 1'b0;
            busy         <= 1'b0;
            cpu_rdata    <= '0;
            ld_rdata     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            we_q         <= we_d;
            ram_addr     <= addr_d;
            ram_wdata    <= wdata_d;
            ram_cs       <= cs_d;
            ram_we       <= ram_we_d;
            ram_oe       <= oe_d;
            ram_wdata_en <= ram_we_d;
            cpu_ack      <= cpu_ack_d;
            ld_ack       <= ld_ack_d;
            busy         <= busy_d;
            if (cpu_cap) cpu_rdata <= ram_rdata;
            if (ld_cap)  ld_rdata  <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: two instances (WAIT_CYCLES=1 and 3) share one stimulus
// stream and are compared each cycle against a timeline model of a transaction.
module tb_ram_arbiter;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;

    logic          clk, reset_n, test_en;
    logic          cpu_req, cpu_we, ld_req, ld_we;
    logic [AW-1:0] cpu_addr, ld_addr;
    logic [DW-1:0] cpu_wdata, ld_wdata, ram_rdata;

    logic          cpu_ack_o [2];
    logic          ld_ack_o [2];
    logic [DW-1:0] cpu_rdata_o [2];
    logic [DW-1:0] ld_rdata_o [2];
    logic          ram_cs_o [2];
    logic          ram_we_o [2];
    logic          ram_oe_o [2];
    logic          ram_wdata_en_o [2];
    logic          busy_o [2];
    logic [AW-1:0] ram_addr_o [2];
    logic [DW-1:0] ram_wdata_o [2];

    int checks = 0;
    int errors = 0;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) dut_w1 (
        .clk(clk), .reset_n(reset_n), .test_en(test_en),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack_o[0]), .cpu_rdata(cpu_rdata_o[0]),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_ack(ld_ack_o[0]), .ld_rdata(ld_rdata_o[0]),
        .ram_cs(ram_cs_o[0]), .ram_we(ram_we_o[0]), .ram_oe(ram_oe_o[0]),
        .ram_addr(ram_addr_o[0]), .ram_wdata(ram_wdata_o[0]),
        .ram_wdata_en(ram_wdata_en_o[0]), .ram_rdata(ram_rdata), .busy(busy_o[0])
    );

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(3)) dut_w3 (
        .clk(clk), .reset_n(reset_n), .test_en(test_en),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack_o[1]), .cpu_rdata(cpu_rdata_o[1]),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_ack(ld_ack_o[1]), .ld_rdata(ld_rdata_o[1]),
        .ram_cs(ram_cs_o[1]), .ram_we(ram_we_o[1]), .ram_oe(ram_oe_o[1]),
        .ram_addr(ram_addr_o[1]), .ram_wdata(ram_wdata_o[1]),
        .ram_wdata_en(ram_wdata_en_o[1]), .ram_rdata(ram_rdata), .busy(busy_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wc(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Winner selection: 1 = loader. A tie goes to the port not granted last.
    function automatic logic pick_ld(input logic c, input logic l, input logic last_ld);
        if (c && l) return !last_ld;
        return l;
    endfunction

    // Model: m_t counts cycles since the grant (0 = idle). 1 = setup,
    // 2..W+1 = access, W+2 = done.
    int            m_t [2];
    logic          m_port [2];
    logic          m_last [2];
    logic          m_we [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_wd [2];
    logic [DW-1:0] m_rc [2];
    logic [DW-1:0] m_rl [2];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                m_t[k] <= 0; m_port[k] <= 1'b0; m_last[k] <= 1'b1; m_we[k] <= 1'b0;
                m_addr[k] <= '0; m_wd[k] <= '0; m_rc[k] <= '0; m_rl[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (m_t[k] == 0) begin
                    if ((cpu_req && !test_en) || ld_req) begin
                        m_t[k] <= 1;
                        if (pick_ld(cpu_req && !test_en, ld_req, m_last[k])) begin
                            m_port[k] <= 1'b1; m_last[k] <= 1'b1; m_we[k] <= ld_we;
                            m_addr[k] <= ld_addr; m_wd[k] <= ld_wdata;
                        end else begin
                            m_port[k] <= 1'b0; m_last[k] <= 1'b0; m_we[k] <= cpu_we;
                            m_addr[k] <= cpu_addr; m_wd[k] <= cpu_wdata;
                        end
                    end
                end else if (m_t[k] == wc(k) + 2) begin
                    m_t[k] <= 0;
                end else begin
                    if (m_t[k] == wc(k) + 1 && !m_we[k]) begin
                        if (m_port[k]) m_rl[k] <= ram_rdata;
                        else           m_rc[k] <= ram_rdata;
                    end
                    m_t[k] <= m_t[k] + 1;
                end
            end
        end
    end

    logic [262:0] exp_v [2];
    logic [262:0] act_v [2];

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            act_v[k] = {ram_cs_o[k], ram_we_o[k], ram_oe_o[k], ram_wdata_en_o[k], busy_o[k],
                        cpu_ack_o[k], ld_ack_o[k], ram_addr_o[k], ram_wdata_o[k],
                        cpu_rdata_o[k], ld_rdata_o[k]};
            exp_v[k] = {(m_t[k] >= 1 && m_t[k] <= wc(k) + 1),
                        (m_t[k] >= 2 && m_t[k] <= wc(k) + 1 && m_we[k]),
                        (m_t[k] >= 2 && m_t[k] <= wc(k) + 1 && !m_we[k]),
                        (m_t[k] >= 2 && m_t[k] <= wc(k) + 1 && m_we[k]),
                        (m_t[k] != 0),
                        (m_t[k] == wc(k) + 2 && !m_port[k]),
                        (m_t[k] == wc(k) + 2 && m_port[k]),
                        m_addr[k], m_wd[k], m_rc[k], m_rl[k]};
        end
    end

    task automatic test_reset();
        reset_n = 1'b0; test_en = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0; ram_rdata = '0;
        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_v[k] !== '0) begin
                    errors++;
                    $display("FAIL reset_zero w%0d got=%h exp=0", wc(k), act_v[k]);
                end
            end
        end
        reset_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_v[k] !== exp_v[k]) begin
                    errors++;
                    $display("FAIL reset_idle w%0d got=%h exp=%h", wc(k), act_v[k], exp_v[k]);
                end
            end
        end
    endtask

    task automatic test_cpu_read();
        int cs_n = 0, oe_n = 0, ack_n = 0, ack_at = 0;
        test_en = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h10;
        ram_rdata = 64'hDEAD_BEEF;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_v[k] !== exp_v[k]) begin
                    errors++;
                    $display("FAIL cpu_read w%0d i=%0d got=%h exp=%h", wc(k), i, act_v[k], exp_v[k]);
                end
            end
            if (i == 1) cpu_req = 1'b0;
            cs_n += int'(ram_cs_o[0]);
            oe_n += int'(ram_oe_o[0]);
            if (cpu_ack_o[0]) begin ack_n++; ack_at = i; end
        end
        checks++;
        if (cs_n != 2 || oe_n != 1) begin
            errors++;
            $display("FAIL cpu_read_strobes cs=%0d oe=%0d exp cs=2 oe=1", cs_n, oe_n);
        end
        checks++;
        if (ack_n != 1 || ack_at != 3) begin
            errors++;
            $display("FAIL cpu_read_ack count=%0d at=%0d exp count=1 at=3", ack_n, ack_at);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (cpu_rdata_o[k] !== 64'hDEAD_BEEF) begin
                errors++;
                $display("FAIL cpu_read_data w%0d got=%h exp=deadbeef", wc(k), cpu_rdata_o[k]);
            end
        end
    endtask

    task automatic test_ld_write();
        int we_n = 0, ack_n = 0;
        test_en = 1'b1; ld_req = 1'b1; ld_we = 1'b1; ld_addr = 64'h20; ld_wdata = 64'h1234;
        ram_rdata = {$urandom, $urandom};
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_v[k] !== exp_v[k]) begin
                    errors++;
                    $display("FAIL ld_write w%0d i=%0d got=%h exp=%h", wc(k), i, act_v[k], exp_v[k]);
                end
            end
            if (i == 1) ld_req = 1'b0;
            if (ram_we_o[0] && ram_wdata_en_o[0] && ram_addr_o[0] == 64'h20 && ram_wdata_o[0] == 64'h1234)
                we_n++;
            ack_n += int'(ld_ack_o[0]);
        end
        checks++;
        if (we_n != 1 || ack_n != 1) begin
            errors++;
            $display("FAIL ld_write_pulse we=%0d ack=%0d exp we=1 ack=1", we_n, ack_n);
        end
        checks++;
        if (cpu_rdata_o[0] !== 64'hDEAD_BEEF || ld_rdata_o[0] !== 64'h0) begin
            errors++;
            $display("FAIL ld_write_rdata cpu=%h ld=%h exp cpu=deadbeef ld=0", cpu_rdata_o[0], ld_rdata_o[0]);
        end
    endtask

    task automatic test_round_robin();
        int   ack_cyc[$];
        logic ack_pt[$];
        test_en = 1'b0; cpu_req = 1'b1; ld_req = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_v[k] !== exp_v[k]) begin
                    errors++;
                    $display("FAIL rr w%0d i=%0d got=%h exp=%h", wc(k), i, act_v[k], exp_v[k]);
                end
            end
            if (cpu_ack_o[0]) begin ack_cyc.push_back(i); ack_pt.push_back(1'b0); end
            if (ld_ack_o[0])  begin ack_cyc.push_back(i); ack_pt.push_back(1'b1); end
            cpu_we = 1'($urandom_range(0, 1)); ld_we = 1'($urandom_range(0, 1));
            cpu_addr = {$urandom, $urandom}; ld_addr = {$urandom, $urandom};
            cpu_wdata = {$urandom, $urandom}; ld_wdata = {$urandom, $urandom};
            ram_rdata = {$urandom, $urandom};
        end
        checks++;
        if (ack_cyc.size() < 8) begin
            errors++;
            $display("FAIL rr_count got=%0d exp>=8", ack_cyc.size());
        end
        for (int j = 0; j < ack_pt.size(); j++) begin
            checks++;
            if (ack_pt[j] !== 1'(j % 2)) begin
                errors++;
                $display("FAIL rr_order j=%0d got=%0d exp=%0d", j, ack_pt[j], j % 2);
            end
            if (j > 0) begin
                checks++;
                if (ack_cyc[j] - ack_cyc[j-1] != 4) begin
                    errors++;
                    $display("FAIL rr_spacing j=%0d got=%0d exp=4", j, ack_cyc[j] - ack_cyc[j-1]);
                end
            end
        end
        cpu_req = 1'b0; ld_req = 1'b0;
        repeat (8) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_v[k] !== exp_v[k]) begin
                    errors++;
                    $display("FAIL rr_drain w%0d got=%h exp=%h", wc(k), act_v[k], exp_v[k]);
                end
            end
        end
    endtask

    task automatic test_test_en();
        int ld_n = 0, cpu_n = 0;
        test_en = 1'b1; cpu_req = 1'b1; ld_req = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_v[k] !== exp_v[k]) begin
                    errors++;
                    $display("FAIL test_en w%0d i=%0d got=%h exp=%h", wc(k), i, act_v[k], exp_v[k]);
                end
                cpu_n += int'(cpu_ack_o[k]);
            end
            ld_n += int'(ld_ack_o[0]);
            cpu_we = 1'($urandom_range(0, 1)); ld_we = 1'($urandom_range(0, 1));
            ld_addr = {$urandom, $urandom}; ld_wdata = {$urandom, $urandom};
            ram_rdata = {$urandom, $urandom};
        end
        checks++;
        if (cpu_n != 0 || ld_n < 10) begin
            errors++;
            $display("FAIL test_en_acks cpu=%0d ld=%0d exp cpu=0 ld>=10", cpu_n, ld_n);
        end
        cpu_req = 1'b0; ld_req = 1'b0; test_en = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int ack_n = 0;
        test_en = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1;
        cpu_addr = {$urandom, $urandom}; cpu_wdata = {$urandom, $urandom};
        @(posedge clk);
        #1 cpu_req = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ram_we_o[0] !== 1'b1 || ram_cs_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre we=%b cs=%b exp we=1 cs=1", ram_we_o[0], ram_cs_o[0]);
        end
        #2 reset_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({ram_cs_o[k], ram_we_o[k], ram_wdata_en_o[k], busy_o[k]} !== 4'b0000) begin
                errors++;
                $display("FAIL rst_mid_async w%0d cs/we/en/busy=%b%b%b%b exp=0000", wc(k),
                         ram_cs_o[k], ram_we_o[k], ram_wdata_en_o[k], busy_o[k]);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_v[k] !== exp_v[k]) begin
                    errors++;
                    $display("FAIL rst_mid_after w%0d got=%h exp=%h", wc(k), act_v[k], exp_v[k]);
                end
                ack_n += int'(cpu_ack_o[k]) + int'(ld_ack_o[k]);
            end
        end
        checks++;
        if (ack_n != 0) begin
            errors++;
            $display("FAIL rst_mid_noack got=%0d exp=0", ack_n);
        end
    endtask

    task automatic test_wait3_drop();
        int oe_n = 0, ack_n = 0, ack_at = 0;
        logic [DW-1:0] rv;
        rv = {$urandom, $urandom};
        test_en = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = {$urandom, $urandom};
        ram_rdata = rv;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_v[k] !== exp_v[k]) begin
                    errors++;
                    $display("FAIL wait3 w%0d i=%0d got=%h exp=%h", wc(k), i, act_v[k], exp_v[k]);
                end
            end
            if (i == 1) cpu_req = 1'b0;
            oe_n += int'(ram_oe_o[1]);
            if (cpu_ack_o[1]) begin ack_n++; ack_at = i; end
        end
        checks++;
        if (oe_n != 3 || ack_n != 1 || ack_at != 5) begin
            errors++;
            $display("FAIL wait3_timing oe=%0d ack=%0d at=%0d exp oe=3 ack=1 at=5", oe_n, ack_n, ack_at);
        end
        checks++;
        if (cpu_rdata_o[1] !== rv) begin
            errors++;
            $display("FAIL wait3_data got=%h exp=%h", cpu_rdata_o[1], rv);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_v[k] !== exp_v[k]) begin
                    errors++;
                    $display("FAIL random w%0d i=%0d got=%h exp=%h", wc(k), i, act_v[k], exp_v[k]);
                end
            end
            if ($urandom_range(0, 7) == 0) test_en = ~test_en;
            cpu_req = 1'($urandom_range(0, 1)); ld_req = 1'($urandom_range(0, 1));
            cpu_we = 1'($urandom_range(0, 1)); ld_we = 1'($urandom_range(0, 1));
            cpu_addr = {$urandom, $urandom}; ld_addr = {$urandom, $urandom};
            cpu_wdata = {$urandom, $urandom}; ld_wdata = {$urandom, $urandom};
            ram_rdata = {$urandom, $urandom};
        end
        cpu_req = 1'b0; ld_req = 1'b0;
        repeat (8) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_v[k] !== exp_v[k]) begin
                    errors++;
                    $display("FAIL random_drain w%0d got=%h exp=%h", wc(k), act_v[k], exp_v[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_ld_write();
        test_round_robin();
        test_test_en();
        test_reset_mid();
        test_wait3_drop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
